alu_writeback: RTL and testbench
================================

Name: alu_writeback

Overview:
- Registered writeback stage directly downstream of the ALU.
- Captures ALU result and status_out per instruction; holds it in a 2-entry skid buffer; presents it to the register-file write port over a valid/ready handshake.
- Owns the architectural flags register (CF/PF/ZF/SF/OF), which feeds ALU status_in.
- Absorbs one cycle of register-file backpressure without a combinational ready path to the ALU.

Parameters:
- DEST_W, 3, width of destination register index.
- RESET_FLAGS, 5'b00000, flags register value after reset; bit order per `STAT_* in defines.v.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous; drops all buffered entries.
- in_valid  input  1  ALU output valid.
- in_ready  output  1  stage can accept; registered, never depends on out_ready combinationally.
- in_result  input  32  ALU result.
- in_status  input  5  ALU status_out.
- in_dest  input  DEST_W  destination register index.
- in_wr_reg  input  1  entry writes register file.
- in_wr_flags  input  1  entry commits in_status to flags.
- out_valid  output  1  head entry valid.
- out_ready  input  1  register file accepts head.
- out_data  output  32  head result.
- out_dest  output  DEST_W  head destination.
- out_wr_reg  output  1  head write enable (qualified by out_valid).
- flags  output  5  architectural flags; drives ALU status_in.

Behaviour:
- Reset (async, rst_n low): state EMPTY, both entries invalid, out_valid=0, in_ready=1, out_data=0, out_dest=0, out_wr_reg=0, flags=RESET_FLAGS. Reset mid-transfer discards all entries; no partial write escapes.
- Accept = in_valid & in_ready. Pop = out_valid & out_ready.
- State machine, 2 entries (head, skid):
  - EMPTY: accept -> ONE (entry into head).
  - ONE: accept & pop -> ONE (new entry into head). Accept only -> TWO (entry into skid). Pop only -> EMPTY.
  - TWO: in_ready=0. Pop -> ONE (skid moves to head, skid cleared). Otherwise hold.
- in_ready is registered: 1 in EMPTY/ONE, 0 in TWO.
- out_valid=1 in ONE/TWO. out_* always reflect the head entry; output order is strictly FIFO.
- Latency: accepted in cycle N -> out_valid in cycle N+1. Throughput 1/cycle while out_ready=1.
- Flags:
  - On accept with in_wr_flags=1, flags<=in_status at that edge, so the next ALU op sees the updated flags in the following cycle.
  - in_wr_flags=0 leaves flags unchanged.
  - Flags update is independent of output backpressure.
- Entries with in_wr_reg=0 still occupy a slot and pop normally, with out_wr_reg=0.
- Flush:
  - Next state EMPTY; all entries invalid; in_ready=1 next cycle.
  - in_ready is forced 0 combinationally while flush=1, so no accept and no flags update in a flush cycle.
  - Flags already committed are not rolled back.
  - Flush and pop in the same cycle: the pop still completes (register file wrote it).
- out_data/out_dest hold their last value when out_valid=0; consumers qualify with out_valid.

Optional Feature:
- Macro ALU_WB_PERF_CNT_EN.
- Defined:
  - Adds output ports retired_cnt[31:0] and stall_cnt[31:0], both reset to 0.
  - retired_cnt increments on every pop.
  - stall_cnt increments each cycle with out_valid=1 & out_ready=0.
  - Both wrap from 32'hFFFFFFFF to 0. Flush does not clear them.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then one accept: in_result=32'h0000_0005, dest=3, wr_reg=1, wr_flags=1, status CF=1/ZF=0, out_ready=1 -> out_valid=1 next cycle with out_data=5, out_dest=3; flags CF=1 one cycle after accept.
- Streaming: 8 back-to-back accepts (results 1..8) with out_ready=1 -> pops 1..8 in order at 1/cycle; in_ready stays 1.
- Backpressure: out_ready=0, accept A=32'hAAAA_AAAA then B=32'hBBBB_BBBB -> state TWO, in_ready=0, third in_valid ignored; raise out_ready -> A then B emitted; in_ready returns to 1 the cycle after A pops.
- Flag gating: accept with wr_flags=0, status=5'b11111, starting from flags=0 -> flags remain 0; next accept with wr_flags=1, status ZF set -> only ZF=1.
- Flush: TWO state plus flush=1 with in_valid=1 -> next cycle EMPTY, out_valid=0, input not accepted, flags unchanged; async rst_n pulse mid-stream -> immediate out_valid=0, flags=RESET_FLAGS.
- ALU_WB_PERF_CNT_EN: 3 pops plus 4 stalled cycles -> retired_cnt=3, stall_cnt=4; preload-style run to 32'hFFFFFFFF then one pop -> retired_cnt=0.

Source files
------------

// File: rtl/alu_writeback_if.sv
// rtl/alu_writeback_if.sv - ALU-side and register-file-side handshake bundle for alu_writeback
interface alu_writeback_if #(
  parameter int DEST_W = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_result;
  logic [4:0]        in_status;
  logic [DEST_W-1:0] in_dest;
  logic              in_wr_reg;
  logic              in_wr_flags;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_data;
  logic [DEST_W-1:0] out_dest;
  logic              out_wr_reg;

  modport slave (
    input  in_valid, in_result, in_status, in_dest, in_wr_reg, in_wr_flags, out_ready,
    output in_ready, out_valid, out_data, out_dest, out_wr_reg
  );

  modport master (
    output in_valid, in_result, in_status, in_dest, in_wr_reg, in_wr_flags, out_ready,
    input  in_ready, out_valid, out_data, out_dest, out_wr_reg
  );
endinterface

// File: rtl/alu_writeback.sv
// rtl/alu_writeback.sv - registered ALU writeback stage: 2-entry skid buffer plus flags register
// Optional retired/stall counters enabled by ALU_WB_PERF_CNT_EN.
module alu_writeback #(
  parameter int         DEST_W      = 3,
  parameter logic [4:0] RESET_FLAGS = 5'b00000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  alu_writeback_if.slave    wb,
  output logic [4:0]        flags
`ifdef ALU_WB_PERF_CNT_EN
  ,
  output logic [31:0]       retired_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic [31:0]       head_data_q, head_data_d;
  logic [DEST_W-1:0] head_dest_q, head_dest_d;
  logic              head_wr_q, head_wr_d;
  logic [31:0]       skid_data_q, skid_data_d;
  logic [DEST_W-1:0] skid_dest_q, skid_dest_d;
  logic              skid_wr_q, skid_wr_d;
  logic [4:0]        flags_q, flags_d;
  logic              accept;
  logic              pop;

  // in_ready comes from a flop; flush only masks it, keeping out_ready off this path
  assign wb.in_ready   = in_ready_q & ~flush;
  assign wb.out_valid  = (state_q != EMPTY);
  assign wb.out_data   = head_data_q;
  assign wb.out_dest   = head_dest_q;
  assign wb.out_wr_reg = head_wr_q & wb.out_valid;
  assign flags         = flags_q;

  assign accept = wb.in_valid & wb.in_ready;
  assign pop    = wb.out_valid & wb.out_ready;

  always_comb begin
    state_d     = state_q;
    head_data_d = head_data_q;
    head_dest_d = head_dest_q;
    head_wr_d   = head_wr_q;
    skid_data_d = skid_data_q;
    skid_dest_d = skid_dest_q;
    skid_wr_d   = skid_wr_q;
    flags_d     = flags_q;

    case (state_q)
      EMPTY: begin
        if (accept) begin
          head_data_d = wb.in_result;
          head_dest_d = wb.in_dest;
          head_wr_d   = wb.in_wr_reg;
          state_d     = ONE;
        end
      end
      ONE: begin
        if (accept && pop) begin
          head_data_d = wb.in_result;
          head_dest_d = wb.in_dest;
          head_wr_d   = wb.in_wr_reg;
        end else if (accept) begin
          skid_data_d = wb.in_result;
          skid_dest_d = wb.in_dest;
          skid_wr_d   = wb.in_wr_reg;
          state_d     = TWO;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          head_data_d = skid_data_q;
          head_dest_d = skid_dest_q;
          head_wr_d   = skid_wr_q;
          skid_data_d = '0;
          skid_dest_d = '0;
          skid_wr_d   = 1'b0;
          state_d     = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase

    // A pop in the flush cycle has already been written by the register file
    if (flush) begin
      state_d = EMPTY;
    end

    if (accept && wb.in_wr_flags) begin
      flags_d = wb.in_status;
    end

    in_ready_d = (state_d != TWO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      head_data_q <= '0;
      head_dest_q <= '0;
      head_wr_q   <= 1'b0;
      skid_data_q <= '0;
      skid_dest_q <= '0;
      skid_wr_q   <= 1'b0;
      flags_q     <= RESET_FLAGS;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      head_data_q <= head_data_d;
      head_dest_q <= head_dest_d;
      head_wr_q   <= head_wr_d;
      skid_data_q <= skid_data_d;
      skid_dest_q <= skid_dest_d;
      skid_wr_q   <= skid_wr_d;
      flags_q     <= flags_d;
    end
  end

`ifdef ALU_WB_PERF_CNT_EN
  logic [31:0] retired_cnt_q, retired_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  assign retired_cnt = retired_cnt_q;
  assign stall_cnt   = stall_cnt_q;

  // Counters wrap naturally and survive flush
  always_comb begin
    retired_cnt_d = retired_cnt_q + {31'd0, pop};
    stall_cnt_d   = stall_cnt_q + {31'd0, (wb.out_valid & ~wb.out_ready)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_cnt_q <= '0;
      stall_cnt_q   <= '0;
    end else begin
      retired_cnt_q <= retired_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// tb/tb_alu_writeback.sv - table-driven, scoreboarded bench for alu_writeback
module tb_alu_writeback;
  localparam logic [4:0] RST_FLAGS = 5'b00000;

  logic clk;
  logic rst_n;
  logic flush;
  logic [4:0] flags;
`ifdef ALU_WB_PERF_CNT_EN
  logic [31:0] retired_cnt;
  logic [31:0] stall_cnt;
`endif

  alu_writeback_if #(.DEST_W(3)) wb ();

  alu_writeback #(.DEST_W(3), .RESET_FLAGS(RST_FLAGS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .wb    (wb),
    .flags (flags)
`ifdef ALU_WB_PERF_CNT_EN
    ,
    .retired_cnt (retired_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] res;
    logic [4:0]  st;
    logic [2:0]  dest;
    logic        wr;
    logic        wf;
    logic        ordy;
    logic        fl;
    logic [4:0]  e_flags;
    logic        e_ir;
    logic        e_ov;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [2:0]  dest;
    logic        wr;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [31:0] res, input logic [4:0] st,
                              input logic [2:0] dest, input logic wr, input logic wf,
                              input logic ordy, input logic fl, input logic [4:0] e_flags,
                              input logic e_ir, input logic e_ov);
    vec_t r;
    r.v = v; r.res = res; r.st = st; r.dest = dest; r.wr = wr; r.wf = wf;
    r.ordy = ordy; r.fl = fl; r.e_flags = e_flags; r.e_ir = e_ir; r.e_ov = e_ov;
    return r;
  endfunction

  // Sample mid-cycle: score pops, drop flushed entries, record accepts; then pass the edge
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    if (wb.out_valid && wb.out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_pop", {29'd0, wb.out_dest}, 32'hxxxx_xxxx);
      end else begin
        e = sb.pop_front();
        chk("out_data", wb.out_data, e.data);
        chk("out_dest", {29'd0, wb.out_dest}, {29'd0, e.dest});
        chk("out_wr_reg", {31'd0, wb.out_wr_reg}, {31'd0, e.wr});
      end
    end
    if (flush) begin
      chk("in_ready_in_flush", {31'd0, wb.in_ready}, 32'd0);
      sb.delete();
    end
    if (wb.in_valid && wb.in_ready) begin
      e.data = wb.in_result;
      e.dest = wb.in_dest;
      e.wr   = wb.in_wr_reg;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb.in_valid    = 1'b0;
    wb.in_result   = '0;
    wb.in_status   = '0;
    wb.in_dest     = '0;
    wb.in_wr_reg   = 1'b0;
    wb.in_wr_flags = 1'b0;
    flush          = 1'b0;
  endtask

  task automatic put(input logic v, input logic [31:0] r, input logic ordy);
    wb.in_valid    = v;
    wb.in_result   = r;
    wb.in_status   = '0;
    wb.in_dest     = 3'd1;
    wb.in_wr_reg   = 1'b1;
    wb.in_wr_flags = 1'b0;
    wb.out_ready   = ordy;
    flush          = 1'b0;
    cycle();
  endtask

  initial begin
    vec_t v;
    idle_inputs();
    wb.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'd0, wb.out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, wb.in_ready}, 32'd1);
    chk("rst_out_data", wb.out_data, 32'd0);
    chk("rst_out_dest", {29'd0, wb.out_dest}, 32'd0);
    chk("rst_out_wr_reg", {31'd0, wb.out_wr_reg}, 32'd0);
    chk("rst_flags", {27'd0, flags}, {27'd0, RST_FLAGS});
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single accept with CF, then drain
    vecs.push_back(mk(1, 32'h0000_0005, 5'b00001, 3'd3, 1, 1, 1, 0, 5'b00001, 1, 1));
    vecs.push_back(mk(0, 32'h0, 5'b0, 3'd0, 0, 0, 1, 0, 5'b00001, 1, 0));
    // Streaming 1..8
    for (int i = 1; i <= 8; i++)
      vecs.push_back(mk(1, 32'(i), 5'b11111, 3'(i), 1, 0, 1, 0, 5'b00001, 1, 1));
    vecs.push_back(mk(0, 32'h0, 5'b0, 3'd0, 0, 0, 1, 0, 5'b00001, 1, 0));
    // Backpressure: A, B fill, C refused, then drain
    vecs.push_back(mk(1, 32'hAAAA_AAAA, 5'b0, 3'd2, 1, 0, 0, 0, 5'b00001, 1, 1));
    vecs.push_back(mk(1, 32'hBBBB_BBBB, 5'b0, 3'd4, 1, 0, 0, 0, 5'b00001, 0, 1));
    vecs.push_back(mk(1, 32'hCCCC_CCCC, 5'b10101, 3'd5, 1, 1, 0, 0, 5'b00001, 0, 1));
    vecs.push_back(mk(0, 32'h0, 5'b0, 3'd0, 0, 0, 1, 0, 5'b00001, 1, 1));
    vecs.push_back(mk(0, 32'h0, 5'b0, 3'd0, 0, 0, 1, 0, 5'b00001, 1, 0));
    // Flag gating
    vecs.push_back(mk(1, 32'h0000_0010, 5'b00000, 3'd1, 1, 1, 1, 0, 5'b00000, 1, 1));
    vecs.push_back(mk(1, 32'h0000_0020, 5'b11111, 3'd2, 0, 0, 1, 0, 5'b00000, 1, 1));
    vecs.push_back(mk(1, 32'h0000_0030, 5'b00100, 3'd6, 1, 1, 1, 0, 5'b00100, 1, 1));
    vecs.push_back(mk(0, 32'h0, 5'b0, 3'd0, 0, 0, 1, 0, 5'b00100, 1, 0));
    // Flush from TWO with in_valid, then flush together with a pop
    vecs.push_back(mk(1, 32'h0000_0011, 5'b0, 3'd1, 1, 0, 0, 0, 5'b00100, 1, 1));
    vecs.push_back(mk(1, 32'h0000_0022, 5'b0, 3'd2, 1, 0, 0, 0, 5'b00100, 0, 1));
    vecs.push_back(mk(1, 32'h0000_0033, 5'b11111, 3'd3, 1, 1, 0, 1, 5'b00100, 1, 0));
    vecs.push_back(mk(1, 32'h0000_0044, 5'b0, 3'd7, 1, 0, 0, 0, 5'b00100, 1, 1));
    vecs.push_back(mk(0, 32'h0, 5'b0, 3'd0, 0, 0, 1, 1, 5'b00100, 1, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      wb.in_valid    = v.v;
      wb.in_result   = v.res;
      wb.in_status   = v.st;
      wb.in_dest     = v.dest;
      wb.in_wr_reg   = v.wr;
      wb.in_wr_flags = v.wf;
      wb.out_ready   = v.ordy;
      flush          = v.fl;
      cycle();
      idle_inputs();
      wb.out_ready = 1'b0;
      #1;
      chk($sformatf("vec%0d_flags", i), {27'd0, flags}, {27'd0, v.e_flags});
      chk($sformatf("vec%0d_in_ready", i), {31'd0, wb.in_ready}, {31'd0, v.e_ir});
      chk($sformatf("vec%0d_out_valid", i), {31'd0, wb.out_valid}, {31'd0, v.e_ov});
    end

    // Async reset in the middle of a held entry
    wb.in_valid    = 1'b1;
    wb.in_result   = 32'h0000_0055;
    wb.in_status   = 5'b01010;
    wb.in_dest     = 3'd5;
    wb.in_wr_reg   = 1'b1;
    wb.in_wr_flags = 1'b1;
    wb.out_ready   = 1'b0;
    cycle();
    idle_inputs();
    #1;
    chk("pre_rst_flags", {27'd0, flags}, 32'h0000_000A);
    chk("pre_rst_out_valid", {31'd0, wb.out_valid}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", {31'd0, wb.out_valid}, 32'd0);
    chk("async_rst_flags", {27'd0, flags}, {27'd0, RST_FLAGS});
    chk("async_rst_in_ready", {31'd0, wb.in_ready}, 32'd1);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

`ifdef ALU_WB_PERF_CNT_EN
    put(1, 32'h0000_0101, 0);
    repeat (4) put(0, 32'h0, 0);
    put(1, 32'h0000_0102, 1);
    put(1, 32'h0000_0103, 1);
    put(0, 32'h0, 1);
    chk("retired_cnt", retired_cnt, 32'd3);
    chk("stall_cnt", stall_cnt, 32'd4);
    dut.retired_cnt_q = 32'hFFFF_FFFF;
    put(1, 32'h0000_0104, 1);
    put(0, 32'h0, 1);
    chk("retired_wrap", retired_cnt, 32'd0);
`else
    put(1, 32'h0000_0101, 0);
    put(0, 32'h0, 1);
`endif

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
